tick_sched: RTL and testbench

TICK_SCHED -- requirements
Module: tick_sched

---
 rtl/tick_sched_pkg.sv | 14 +
 rtl/tick_sched_if.sv | 27 ++
 rtl/tick_chan.sv | 56 +++++
 rtl/tick_sched.sv | 123 ++++++++++++
 tb/tb_tick_sched.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tick_sched_pkg.sv
// Shared definitions for the tick scheduler.
//   NchDefault / PwDefault : default channel count and period width
//   arb_state_e            : event arbiter states
package tick_sched_pkg;

  localparam int unsigned NchDefault = 4;
  localparam int unsigned PwDefault  = 8;

  typedef enum logic [0:0] {
    IDLE,
    OFFER
  } arb_state_e;

endpackage

// File: rtl/tick_sched_if.sv
// Event offer channel between the tick scheduler and its consumer.
//   evt_valid : event offered (scheduler -> consumer)
//   evt_ch    : channel of the offered event (scheduler -> consumer)
//   evt_ready : consumer accepts the offered event (consumer -> scheduler)
interface tick_sched_if
  import tick_sched_pkg::*;
#(
  parameter int unsigned NCH = NchDefault
);

  logic                   evt_valid;
  logic [$clog2(NCH)-1:0] evt_ch;
  logic                   evt_ready;

  modport master (
    output evt_valid,
    output evt_ch,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_ch,
    output evt_ready
  );

endinterface

// File: rtl/tick_chan.sv
// One scheduler channel: period register plus tick counter.
//   clk, rst_n  : clock, async active-low reset
//   tick_in     : timebase strobe
//   enable      : channel run enable
//   cfg_we      : period write for this channel (already decoded)
//   cfg_period  : new period, 0 disables the channel
//   fire        : one-cycle pulse when the counter reaches its period
module tick_chan
  import tick_sched_pkg::*;
#(
  parameter int unsigned PW = PwDefault
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick_in,
  input  logic          enable,
  input  logic          cfg_we,
  input  logic [PW-1:0] cfg_period,
  output logic          fire
);

  logic [PW-1:0] per_q, per_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic          active;
  logic          at_end;

  always_comb begin
    active = enable && (per_q != '0);
    // Only meaningful while active, so per_q - 1 never underflows in use.
    at_end = (cnt_q == per_q - PW'(1));
    // A config write swallows a coincident tick for this channel.
    fire   = active && tick_in && !cfg_we && at_end;

    per_d = per_q;
    cnt_d = cnt_q;
    if (cfg_we) begin
      per_d = cfg_period;
      cnt_d = '0;
    end else if (!active) begin
      cnt_d = '0;
    end else if (tick_in) begin
      cnt_d = at_end ? '0 : cnt_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_q <= '0;
      cnt_q <= '0;
    end else begin
      per_q <= per_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tick_sched.sv
// Periodic event scheduler: NCH tick-driven channels feeding a round-robin
// arbiter that offers one event at a time on a valid/ready channel.
//   clk, rst_n         : clock, async active-low reset
//   tick_in            : timebase strobe
//   enable             : per-channel run enable
//   cfg_we/ch/period   : period write port
//   overrun            : sticky per-channel overrun flags
//   ovr_clr            : clear all overrun flags
//   evt                : event offer interface (master side)
module tick_sched
  import tick_sched_pkg::*;
#(
  parameter int unsigned NCH = NchDefault,
  parameter int unsigned PW  = PwDefault
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tick_in,
  input  logic [NCH-1:0]         enable,
  input  logic                   cfg_we,
  input  logic [$clog2(NCH)-1:0] cfg_ch,
  input  logic [PW-1:0]          cfg_period,
  output logic [NCH-1:0]         overrun,
  input  logic                   ovr_clr,
  tick_sched_if.master           evt
);

  localparam int unsigned CW = $clog2(NCH);

  logic [NCH-1:0] fire;
  logic [NCH-1:0] cfg_sel;
  logic [NCH-1:0] pending_q, pending_d;
  logic [NCH-1:0] overrun_q, overrun_d;
  logic [NCH-1:0] grant_mask;
  logic [NCH-1:0] ovr_set;
  logic [CW-1:0]  evt_ch_q, evt_ch_d;
  logic [CW-1:0]  last_grant_q, last_grant_d;
  logic [CW-1:0]  rr_ch;
  logic           rr_vld;
  arb_state_e     state_q, state_d;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    assign cfg_sel[i] = cfg_we && (cfg_ch == CW'(i));

    tick_chan #(
      .PW(PW)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick_in    (tick_in),
      .enable     (enable[i]),
      .cfg_we     (cfg_sel[i]),
      .cfg_period (cfg_period),
      .fire       (fire[i])
    );
  end

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    rr_vld = 1'b0;
    rr_ch  = '0;
    for (int unsigned k = 1; k <= NCH; k++) begin
      int unsigned    idx;
      logic [NCH-1:0] onehot;
      idx    = (32'(last_grant_q) + k) % NCH;
      onehot = NCH'(1) << idx;
      if (!rr_vld && |(pending_q & onehot)) begin
        rr_vld = 1'b1;
        rr_ch  = CW'(idx);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    evt_ch_d     = evt_ch_q;
    last_grant_d = last_grant_q;
    grant_mask   = '0;
    unique case (state_q)
      IDLE: begin
        if (rr_vld) begin
          evt_ch_d   = rr_ch;
          grant_mask = NCH'(1) << rr_ch;
          state_d    = OFFER;
        end
      end
      OFFER: begin
        if (evt.evt_ready) begin
          last_grant_d = evt_ch_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A fire on the channel being granted re-arms pending without overrun.
    ovr_set   = fire & pending_q & ~grant_mask;
    pending_d = (pending_q & ~grant_mask) | fire;
    overrun_d = (ovr_clr ? '0 : overrun_q) | ovr_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      evt_ch_q     <= '0;
      last_grant_q <= CW'(NCH - 1);
      pending_q    <= '0;
      overrun_q    <= '0;
    end else begin
      state_q      <= state_d;
      evt_ch_q     <= evt_ch_d;
      last_grant_q <= last_grant_d;
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
    end
  end

  // Valid comes straight from the state register so reset drops it at once.
  assign evt.evt_valid = (state_q == OFFER);
  assign evt.evt_ch    = evt_ch_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_tick_sched.sv
// Directed self-checking bench for tick_sched (NCH=4, PW=8).
module tb_tick_sched;

  localparam int unsigned NCH = 4;
  localparam int unsigned PW  = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           tick_in = 1'b0;
  logic [NCH-1:0] enable = '0;
  logic           cfg_we = 1'b0;
  logic [1:0]     cfg_ch = '0;
  logic [PW-1:0]  cfg_period = '0;
  logic           ovr_clr = 1'b0;
  logic [NCH-1:0] overrun;

  int n_tests = 0;
  int n_fail  = 0;

  tick_sched_if #(.NCH(NCH)) evt_if ();

  tick_sched #(
    .NCH(NCH),
    .PW (PW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_in    (tick_in),
    .enable     (enable),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_period (cfg_period),
    .overrun    (overrun),
    .ovr_clr    (ovr_clr),
    .evt        (evt_if)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input logic [1:0] ch, input logic [PW-1:0] per);
    cfg_ch     = ch;
    cfg_period = per;
    cfg_we     = 1'b1;
    step();
    cfg_we     = 1'b0;
  endtask

  task automatic reset_dut();
    rst_n            = 1'b0;
    tick_in          = 1'b0;
    enable           = '0;
    cfg_we           = 1'b0;
    ovr_clr          = 1'b0;
    evt_if.evt_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // One tick, then sample the offer two cycles later; total gap cycles used.
  task automatic tick_obs(input int gap, output logic v, output logic [1:0] c);
    tick_in = 1'b1;
    step();
    tick_in = 1'b0;
    step();
    v = evt_if.evt_valid;
    c = evt_if.evt_ch;
    for (int i = 2; i < gap; i++) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic       v;
    logic [1:0] c;
    logic       prev_v;
    int         rise_n;
    int         rise_t[3];

    evt_if.evt_ready = 1'b0;

    // Reset state
    step();
    check_eq("rst_valid", evt_if.evt_valid, 0);
    check_eq("rst_ch", evt_if.evt_ch, 0);
    check_eq("rst_ovr", overrun, 0);

    // Single channel, period 3, tick every 10 cycles
    reset_dut();
    enable = 4'b0001;
    evt_if.evt_ready = 1'b1;
    do_cfg(2'd0, 8'd3);
    for (int j = 1; j <= 9; j++) begin
      tick_obs(10, v, c);
      check_eq($sformatf("p3_valid_t%0d", j), v, (j % 3 == 0));
      if (j % 3 == 0) check_eq($sformatf("p3_ch_t%0d", j), c, 0);
    end
    check_eq("p3_ovr", overrun, 0);

    // All channels period 1: round-robin with an idle cycle between offers
    reset_dut();
    enable = 4'b1111;
    evt_if.evt_ready = 1'b1;
    for (int ch = 0; ch < 4; ch++) do_cfg(2'(ch), 8'd1);
    tick_in = 1'b1;
    step();
    tick_in = 1'b0;
    check_eq("rr_t1_valid", evt_if.evt_valid, 0);
    for (int k = 0; k < 8; k++) begin
      step();
      check_eq($sformatf("rr_valid_%0d", k), evt_if.evt_valid, (k % 2 == 0));
      if (k % 2 == 0) check_eq($sformatf("rr_ch_%0d", k), evt_if.evt_ch, k / 2);
    end
    tick_in = 1'b1;
    step();
    tick_in = 1'b0;
    step();
    check_eq("rr_wrap_valid", evt_if.evt_valid, 1);
    check_eq("rr_wrap_ch", evt_if.evt_ch, 0);
    check_eq("rr_ovr", overrun, 0);

    // Backpressure: offer held stable, overrun, clear, set-wins, fire-on-select
    reset_dut();
    enable = 4'b0100;
    do_cfg(2'd2, 8'd1);
    for (int j = 1; j <= 3; j++) begin
      tick_obs(3, v, c);
      check_eq($sformatf("bp_valid_%0d", j), v, 1);
      check_eq($sformatf("bp_ch_%0d", j), c, 2);
    end
    check_eq("bp_ovr_set", overrun, 4'b0100);
    tick_in = 1'b1;
    ovr_clr = 1'b1;
    step();
    tick_in = 1'b0;
    ovr_clr = 1'b0;
    check_eq("bp_set_wins", overrun, 4'b0100);
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    check_eq("bp_ovr_clr", overrun, 0);
    check_eq("bp_still_valid", evt_if.evt_valid, 1);
    check_eq("bp_still_ch", evt_if.evt_ch, 2);
    evt_if.evt_ready = 1'b1;
    step();
    check_eq("bp_hs_idle", evt_if.evt_valid, 0);
    tick_in = 1'b1;
    step();
    tick_in = 1'b0;
    check_eq("sel_fire_valid", evt_if.evt_valid, 1);
    check_eq("sel_fire_ovr", overrun, 0);
    step();
    check_eq("sel_fire_idle", evt_if.evt_valid, 0);
    step();
    check_eq("sel_fire_reoffer", evt_if.evt_valid, 1);
    check_eq("sel_fire_reoffer_ch", evt_if.evt_ch, 2);
    step();
    step();
    check_eq("sel_fire_drained", evt_if.evt_valid, 0);

    // Config write coincident with tick: counter cleared, tick ignored
    reset_dut();
    enable = 4'b0010;
    evt_if.evt_ready = 1'b1;
    do_cfg(2'd1, 8'd7);
    for (int j = 1; j <= 2; j++) begin
      tick_obs(3, v, c);
      check_eq($sformatf("cfgt_pre_%0d", j), v, 0);
    end
    cfg_ch     = 2'd1;
    cfg_period = 8'd5;
    cfg_we     = 1'b1;
    tick_in    = 1'b1;
    step();
    cfg_we  = 1'b0;
    tick_in = 1'b0;
    step();
    step();
    for (int j = 1; j <= 5; j++) begin
      tick_obs(3, v, c);
      check_eq($sformatf("cfgt_valid_%0d", j), v, (j == 5));
      if (j == 5) check_eq("cfgt_ch", c, 1);
    end

    // Asynchronous reset during an offer
    reset_dut();
    enable = 4'b1000;
    do_cfg(2'd3, 8'd1);
    tick_in = 1'b1;
    step();
    tick_in = 1'b0;
    step();
    check_eq("ar_pre_valid", evt_if.evt_valid, 1);
    check_eq("ar_pre_ch", evt_if.evt_ch, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("ar_async_valid", evt_if.evt_valid, 0);
    check_eq("ar_async_ch", evt_if.evt_ch, 0);
    check_eq("ar_async_ovr", overrun, 0);
    step();
    rst_n = 1'b1;
    evt_if.evt_ready = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      tick_obs(3, v, c);
      check_eq($sformatf("ar_post_%0d", j), v, 0);
    end

    // Maximum period 255 with continuous ticks; enable drop keeps pending
    reset_dut();
    enable = 4'b0001;
    evt_if.evt_ready = 1'b1;
    do_cfg(2'd0, 8'd255);
    tick_in = 1'b1;
    prev_v  = 1'b0;
    rise_n  = 0;
    rise_t  = '{0, 0, 0};
    for (int n = 1; n <= 1021; n++) begin
      step();
      if (n == 520) evt_if.evt_ready = 1'b0;
      if (evt_if.evt_valid && !prev_v) begin
        if (rise_n < 3) rise_t[rise_n] = n;
        rise_n++;
      end
      prev_v = evt_if.evt_valid;
    end
    check_eq("p255_rises", rise_n, 3);
    check_eq("p255_first", rise_t[0], 256);
    check_eq("p255_second", rise_t[1], 511);
    check_eq("p255_third", rise_t[2], 766);
    tick_in = 1'b0;
    enable  = 4'b0000;
    check_eq("en_drop_held", evt_if.evt_valid, 1);
    evt_if.evt_ready = 1'b1;
    step();
    check_eq("en_drop_hs", evt_if.evt_valid, 0);
    step();
    check_eq("en_drop_deliver", evt_if.evt_valid, 1);
    check_eq("en_drop_ch", evt_if.evt_ch, 0);
    check_eq("en_drop_ovr", overrun, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
